// File: rtl/tetris_pkg.sv
// Shared Tetris game-control definitions: command codes and key-repeat channel states.
package tetris_pkg;

  localparam logic [1:0] CMD_LEFT  = 2'd0;
  localparam logic [1:0] CMD_RIGHT = 2'd1;
  localparam logic [1:0] CMD_DOWN  = 2'd2;
  localparam logic [1:0] CMD_ROT   = 2'd3;

  localparam int unsigned NUM_CHAN = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DAS  = 2'd1,
    RPT  = 2'd2
  } chan_state_t;

endpackage

// File: rtl/key_repeat_cmd_if.sv
// Command handshake from the key-repeat block to the game-control FSM, plus drop indication.
interface key_repeat_cmd_if;

  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       drop_pulse;

  modport master (
    output cmd_valid,
    output cmd,
    output drop_pulse,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd,
    input  drop_pulse,
    output cmd_ready
  );

endinterface

// File: rtl/key_repeat_chan.sv
// One button channel: press edge detect plus DAS/ARR repeat timing, emitting a request pulse.
// req is combinational and meant to be captured at the same edge the press/repeat is sampled.
module key_repeat_chan
  import tetris_pkg::*;
#(
  parameter int unsigned DAS_DELAY  = 16,
  parameter int unsigned ARR_PERIOD = 4,
  parameter bit          REPEAT_EN  = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic req
);

  localparam logic [CNT_W-1:0] DAS_CNT = CNT_W'(DAS_DELAY);
  localparam logic [CNT_W-1:0] ARR_CNT = CNT_W'(ARR_PERIOD);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic             pb_q;
  logic             rise;
  chan_state_t      state;
  chan_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign rise = level & ~pb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_q  <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      pb_q  <= level;
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req       = 1'b0;
    if (!level) begin
      // Release from any state; an already-raised request stays pending upstream.
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            req       = 1'b1;
            cnt_nxt   = ONE;
            state_nxt = DAS;
          end
        end
        DAS: begin
          if (cnt == DAS_CNT) begin
            // Press-only channels park here with the counter saturated.
            if (REPEAT_EN) begin
              req       = 1'b1;
              cnt_nxt   = ONE;
              state_nxt = RPT;
            end
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
        RPT: begin
          if (cnt == ARR_CNT) begin
            req     = 1'b1;
            cnt_nxt = ONE;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_repeat_cmd.sv
// Debounced buttons -> press/auto-repeat commands, fixed priority left>right>down>rotate.
// Press sampled at edge N gives cmd_valid after N+1; cmd holds while !cmd_ready, colliding requests drop.
module key_repeat_cmd
  import tetris_pkg::*;
#(
  parameter int unsigned DAS_DELAY   = 16,
  parameter int unsigned ARR_PERIOD  = 4,
  parameter logic [3:0]  REPEAT_MASK = 4'b0111,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       pb_level,
  key_repeat_cmd_if.master cmd_bus
);

  logic [3:0] req;
  logic [3:0] pend;
  logic [3:0] pend_nxt;
  logic [3:0] clr;
  logic [1:0] pick;
  logic       any_pend;
  logic       load;
  logic       drop_nxt;
  logic       cmd_valid_q;
  logic [1:0] cmd_q;
  logic       drop_q;

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
    key_repeat_chan #(
      .DAS_DELAY (DAS_DELAY),
      .ARR_PERIOD(ARR_PERIOD),
      .REPEAT_EN (REPEAT_MASK[i]),
      .CNT_W     (CNT_W)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .level(pb_level[i]),
      .req  (req[i])
    );
  end

  assign any_pend = |pend;
  assign load     = !cmd_valid_q || cmd_bus.cmd_ready;

  always_comb begin
    pick = CMD_LEFT;
    if (pend[0])      pick = CMD_LEFT;
    else if (pend[1]) pick = CMD_RIGHT;
    else if (pend[2]) pick = CMD_DOWN;
    else if (pend[3]) pick = CMD_ROT;
  end

  always_comb begin
    clr = 4'b0000;
    if (load && any_pend) clr = 4'b0001 << pick;
  end

  // A fresh request on the channel being loaded this edge is kept (set beats clear).
  assign pend_nxt = (pend & ~clr) | req;
  assign drop_nxt = |(req & pend & ~clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= 4'b0000;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_LEFT;
      drop_q      <= 1'b0;
    end else begin
      pend   <= pend_nxt;
      drop_q <= drop_nxt;
      if (load) begin
        cmd_valid_q <= any_pend;
        if (any_pend) cmd_q <= pick;
      end
    end
  end

  assign cmd_bus.cmd_valid  = cmd_valid_q;
  assign cmd_bus.cmd        = cmd_q;
  assign cmd_bus.drop_pulse = drop_q;

endmodule

// File: tb/tb_key_repeat_cmd.sv
// Directed and random stimulus against a hold-count reference model of the key-repeat command block.
module tb_key_repeat_cmd;
  import tetris_pkg::*;

  localparam int         D    = 16;
  localparam int         A    = 4;
  localparam logic [3:0] MASK = 4'b0111;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [3:0] pb_level = 4'b0000;

  key_repeat_cmd_if bus ();

  key_repeat_cmd #(
    .DAS_DELAY  (D),
    .ARR_PERIOD (A),
    .REPEAT_MASK(MASK),
    .CNT_W      (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pb_level(pb_level),
    .cmd_bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: hold length per button, pending set, output register, drop flag.
  int         hold_k[4];
  logic [3:0] m_pend;
  logic       m_vld;
  logic [1:0] m_cmd;
  logic       m_drop;

  int acc[4];
  int drops_seen;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [3:0] rq;
    logic [3:0] cl;
    int         pk;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hold_k[i] = 0;
      m_pend = 4'b0000;
      m_vld  = 1'b0;
      m_cmd  = 2'd0;
      m_drop = 1'b0;
      return;
    end
    rq = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (pb_level[i]) begin
        hold_k[i]++;
        if (hold_k[i] == 1) rq[i] = 1'b1;
        else if (MASK[i] && hold_k[i] > D && ((hold_k[i] - 1 - D) % A) == 0) rq[i] = 1'b1;
      end else begin
        hold_k[i] = 0;
      end
    end
    cl = 4'b0000;
    if (!m_vld || bus.cmd_ready) begin
      pk = -1;
      for (int i = 3; i >= 0; i--) if (m_pend[i]) pk = i;
      if (pk >= 0) begin
        m_vld  = 1'b1;
        m_cmd  = 2'(pk);
        cl[pk] = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
    end
    m_drop = |(rq & m_pend & ~cl);
    m_pend = (m_pend & ~cl) | rq;
  endtask

  task automatic step();
    if (rst_n && bus.cmd_valid === 1'b1 && bus.cmd_ready) acc[bus.cmd]++;
    @(posedge clk);
    #1;
    model_edge();
    chk("cmd_valid", 8'(bus.cmd_valid), 8'(m_vld));
    chk("cmd", 8'(bus.cmd), 8'(m_cmd));
    chk("drop_pulse", 8'(bus.drop_pulse), 8'(m_drop));
    if (bus.drop_pulse === 1'b1) drops_seen++;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) acc[i] = 0;
    drops_seen = 0;
  endtask

  initial begin
    bus.cmd_ready = 1'b1;
    clear_counts();

    // Reset
    #1;
    chk("reset_valid", 8'(bus.cmd_valid), 8'd0);
    chk("reset_cmd", 8'(bus.cmd), 8'd0);
    chk("reset_drop", 8'(bus.drop_pulse), 8'd0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (6) step();

    // Tap left for three samples
    clear_counts();
    pb_level = 4'b0001;
    step();
    chk("tap_not_yet_valid", 8'(bus.cmd_valid), 8'd0);
    step();
    chk("tap_valid_next", 8'(bus.cmd_valid), 8'd1);
    chk("tap_cmd_left", 8'(bus.cmd), 8'(CMD_LEFT));
    step();
    pb_level = 4'b0000;
    repeat (30) step();
    chk("tap_left_count", 8'(acc[0]), 8'd1);
    chk("tap_other_count", 8'(acc[1] + acc[2] + acc[3]), 8'd0);

    // Hold right for 31 samples: press, DAS, then three ARR repeats
    clear_counts();
    pb_level = 4'b0010;
    repeat (31) step();
    pb_level = 4'b0000;
    repeat (20) step();
    chk("hold_right_count", 8'(acc[1]), 8'd5);

    // Rotate is press-only
    clear_counts();
    pb_level = 4'b1000;
    repeat (50) step();
    pb_level = 4'b0000;
    repeat (10) step();
    chk("rotate_count", 8'(acc[3]), 8'd1);

    // Simultaneous left + down
    clear_counts();
    pb_level = 4'b0101;
    step();
    pb_level = 4'b0000;
    step();
    chk("simul_first", 8'(bus.cmd), 8'(CMD_LEFT));
    step();
    chk("simul_second", 8'(bus.cmd), 8'(CMD_DOWN));
    chk("simul_second_vld", 8'(bus.cmd_valid), 8'd1);
    repeat (5) step();

    // Backpressure with right held 40 samples
    clear_counts();
    bus.cmd_ready = 1'b0;
    pb_level = 4'b0010;
    repeat (40) step();
    pb_level = 4'b0000;
    repeat (3) step();
    chk("bp_stable_cmd", 8'(bus.cmd), 8'(CMD_RIGHT));
    chk("bp_stable_vld", 8'(bus.cmd_valid), 8'd1);
    chk("bp_drop_count", 8'(drops_seen), 8'd5);
    bus.cmd_ready = 1'b1;
    repeat (6) step();
    chk("bp_accepts", 8'(acc[1]), 8'd2);
    chk("bp_idle_after", 8'(bus.cmd_valid), 8'd0);

    // Reset mid-repeat with left still held
    clear_counts();
    pb_level = 4'b0001;
    repeat (25) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 8'(bus.cmd_valid), 8'd0);
    chk("midrst_cmd", 8'(bus.cmd), 8'd0);
    chk("midrst_drop", 8'(bus.drop_pulse), 8'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("postrst_not_yet", 8'(bus.cmd_valid), 8'd0);
    step();
    chk("postrst_valid", 8'(bus.cmd_valid), 8'd1);
    chk("postrst_cmd", 8'(bus.cmd), 8'(CMD_LEFT));
    pb_level = 4'b0000;
    repeat (10) step();

    // Random buttons, backpressure and occasional reset
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 11) == 0) pb_level[i] = ~pb_level[i];
      bus.cmd_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;
    pb_level = 4'b0000;
    bus.cmd_ready = 1'b1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
